// File: rtl/l1d_axi_bridge.sv
// Bridges the L1 data cache memory port onto an AXI4 master: line-fill bursts,
// single-beat uncacheable reads and single-beat strobed writes.
module l1d_axi_bridge #(
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned DATA_W     = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              D_rreq,
   input  logic              D_wreq,
   input  logic [DATA_W-1:0] D_addr,
   input  logic [DATA_W-1:0] D_in,
   input  logic [2:0]        D_type,
   input  logic              arlenone,
   output logic [DATA_W-1:0] D_out,
   output logic              D_wait,
   output logic [DATA_W-1:0] ARADDR,
   output logic [3:0]        ARLEN,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [DATA_W-1:0] RDATA,
   input  logic              RLAST,
   input  logic              RVALID,
   output logic              RREADY,
   output logic [DATA_W-1:0] AWADDR,
   output logic              AWVALID,
   input  logic              AWREADY,
   output logic [DATA_W-1:0] WDATA,
   output logic [3:0]        WSTRB,
   output logic              WVALID,
   input  logic              WREADY,
   input  logic              BVALID,
   output logic              BREADY
);

   // D_type encoding used by the cache: 0 = byte, 1 = halfword, anything else = word
   localparam logic [2:0] T_BYTE  = 3'd0;
   localparam logic [2:0] T_HWORD = 3'd1;
   localparam logic [3:0] FILL_LEN = 4'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RADDR,
      S_RDATA,
      S_WREQ,
      S_WRESP,
      S_DONE
   } state_t;

   state_t     state;
   logic [3:0] beat_cnt;
   logic [3:0] wstrb_c;

   // Byte-lane strobes from access size and low address bits
   always_comb begin
      wstrb_c = 4'b1111;
      if (D_type == T_BYTE) begin
         wstrb_c = 4'b0001 << D_addr[1:0];
      end else if (D_type == T_HWORD) begin
         wstrb_c = D_addr[1] ? 4'b1100 : 4'b0011;
      end
   end

   // Cache handshake follows the AXI data/response handshakes with no added latency
   assign D_wait = ~((RVALID & RREADY) | (BVALID & BREADY));
   assign D_out  = (RVALID & RREADY) ? RDATA : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= S_IDLE;
         beat_cnt <= '0;
         ARADDR   <= '0;
         ARLEN    <= '0;
         ARVALID  <= 1'b0;
         RREADY   <= 1'b0;
         AWADDR   <= '0;
         AWVALID  <= 1'b0;
         WDATA    <= '0;
         WSTRB    <= '0;
         WVALID   <= 1'b0;
         BREADY   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // Writes win when both requests arrive together
               if (D_wreq) begin
                  AWADDR  <= D_addr;
                  WDATA   <= D_in;
                  WSTRB   <= wstrb_c;
                  AWVALID <= 1'b1;
                  WVALID  <= 1'b1;
                  state   <= S_WREQ;
               end else if (D_rreq) begin
                  ARADDR  <= D_addr;
                  ARLEN   <= arlenone ? 4'd0 : FILL_LEN;
                  ARVALID <= 1'b1;
                  state   <= S_RADDR;
               end
            end
            S_RADDR: begin
               if (ARREADY) begin
                  ARVALID  <= 1'b0;
                  RREADY   <= 1'b1;
                  beat_cnt <= '0;
                  state    <= S_RDATA;
               end
            end
            S_RDATA: begin
               // Beat counter bounds the burst even if RLAST never shows up
               if (RVALID) begin
                  beat_cnt <= beat_cnt + 4'd1;
                  if (RLAST || (beat_cnt == ARLEN)) begin
                     RREADY <= 1'b0;
                     state  <= S_DONE;
                  end
               end
            end
            S_WREQ: begin
               if (AWREADY) AWVALID <= 1'b0;
               if (WREADY)  WVALID  <= 1'b0;
               if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
                  BREADY <= 1'b1;
                  state  <= S_WRESP;
               end
            end
            S_WRESP: begin
               if (BVALID) begin
                  BREADY <= 1'b0;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               // Swallows the cache's trailing request cycle
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l1d_axi_bridge.sv
// Directed bench for l1d_axi_bridge: fills, uncacheable reads, strobed writes,
// request collisions, stalls, beat-count exit and mid-burst reset.
module tb_l1d_axi_bridge;

   localparam logic [2:0] T_BYTE  = 3'd0;
   localparam logic [2:0] T_HWORD = 3'd1;

   logic        clk, rstn;
   logic        D_rreq, D_wreq;
   logic [31:0] D_addr, D_in;
   logic [2:0]  D_type;
   logic        arlenone;
   logic [31:0] D_out;
   logic        D_wait;
   logic [31:0] ARADDR;
   logic [3:0]  ARLEN;
   logic        ARVALID, ARREADY;
   logic [31:0] RDATA;
   logic        RLAST, RVALID, RREADY;
   logic [31:0] AWADDR;
   logic        AWVALID, AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID, WREADY, BVALID, BREADY;

   int total = 0;
   int bad   = 0;
   int pulses = 0;
   int ar_hs  = 0;
   int p0, a0;
   int gaps[4] = '{0, 3, 5, 1};

   l1d_axi_bridge #(.LINE_WORDS(4), .DATA_W(32)) dut (
      .clk(clk), .rstn(rstn),
      .D_rreq(D_rreq), .D_wreq(D_wreq), .D_addr(D_addr), .D_in(D_in),
      .D_type(D_type), .arlenone(arlenone), .D_out(D_out), .D_wait(D_wait),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BVALID(BVALID), .BREADY(BREADY)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) if (D_wait === 1'b0) pulses++;
   always @(posedge clk) if (rstn && ARVALID && ARREADY) ar_hs++;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic samp;
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rstn = 1'b0; D_rreq = 1'b0; D_wreq = 1'b0; D_addr = '0; D_in = '0;
      D_type = '0; arlenone = 1'b0; ARREADY = 1'b0; RDATA = '0; RLAST = 1'b0;
      RVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;

      // reset state
      repeat (2) samp;
      chk("rst_arvalid", 32'(ARVALID), 32'd0);
      chk("rst_rready",  32'(RREADY),  32'd0);
      chk("rst_awvalid", 32'(AWVALID), 32'd0);
      chk("rst_wvalid",  32'(WVALID),  32'd0);
      chk("rst_bready",  32'(BREADY),  32'd0);
      chk("rst_dwait",   32'(D_wait),  32'd1);
      chk("rst_dout",    D_out,  32'd0);
      chk("rst_araddr",  ARADDR, 32'd0);
      chk("rst_awaddr",  AWADDR, 32'd0);
      chk("rst_wdata",   WDATA,  32'd0);
      chk("rst_arlen",   32'(ARLEN), 32'd0);
      chk("rst_wstrb",   32'(WSTRB), 32'd0);
      tick; rstn = 1'b1;

      // cacheable line fill, ARREADY two cycles late
      tick; D_rreq = 1'b1; D_addr = 32'h0001_0040; arlenone = 1'b0;
      p0 = pulses; a0 = ar_hs;
      tick; D_rreq = 1'b0;
      samp;
      chk("fill_arvalid", 32'(ARVALID), 32'd1);
      chk("fill_arlen",   32'(ARLEN),   32'd3);
      chk("fill_araddr",  ARADDR, 32'h0001_0040);
      tick; samp; chk("fill_ar_hold1", 32'(ARVALID), 32'd1);
      tick; ARREADY = 1'b1; samp; chk("fill_ar_hold2", 32'(ARVALID), 32'd1);
      tick; ARREADY = 1'b0; samp;
      chk("fill_ar_drop",  32'(ARVALID), 32'd0);
      chk("fill_rready",   32'(RREADY),  32'd1);
      chk("fill_nobeat",   32'(D_wait),  32'd1);
      for (int i = 0; i < 4; i++) begin
         tick; RVALID = 1'b1; RDATA = 32'hA + 32'(i); RLAST = (i == 3);
         samp;
         chk("fill_beat_wait", 32'(D_wait), 32'd0);
         chk("fill_beat_data", D_out, 32'hA + 32'(i));
      end
      tick; RVALID = 1'b0; RLAST = 1'b0;
      samp;
      chk("fill_done_rready", 32'(RREADY), 32'd0);
      chk("fill_done_wait",   32'(D_wait), 32'd1);
      tick; samp;
      chk("fill_idle_arvalid", 32'(ARVALID), 32'd0);
      chk("fill_pulses", 32'(pulses - p0), 32'd4);
      chk("fill_ar_count", 32'(ar_hs - a0), 32'd1);

      // uncacheable single-beat read
      tick; D_rreq = 1'b1; arlenone = 1'b1; D_addr = 32'h1000_0004;
      p0 = pulses;
      tick; D_rreq = 1'b0; arlenone = 1'b0; ARREADY = 1'b1;
      samp;
      chk("unc_arvalid", 32'(ARVALID), 32'd1);
      chk("unc_arlen",   32'(ARLEN), 32'd0);
      chk("unc_araddr",  ARADDR, 32'h1000_0004);
      tick; ARREADY = 1'b0; RVALID = 1'b1; RDATA = 32'hDEAD_BEEF; RLAST = 1'b1;
      samp;
      chk("unc_wait", 32'(D_wait), 32'd0);
      chk("unc_data", D_out, 32'hDEAD_BEEF);
      tick; RVALID = 1'b0; RLAST = 1'b0;
      samp; chk("unc_done_rready", 32'(RREADY), 32'd0);
      tick;
      chk("unc_pulses", 32'(pulses - p0), 32'd1);

      // byte write: W accepted 3 cycles before AW, BVALID early
      tick; D_wreq = 1'b1; D_type = T_BYTE; D_addr = 32'h2000_0002; D_in = 32'h0055_0000;
      p0 = pulses;
      tick; D_wreq = 1'b0; WREADY = 1'b1;
      samp;
      chk("bw_awvalid", 32'(AWVALID), 32'd1);
      chk("bw_wvalid",  32'(WVALID),  32'd1);
      chk("bw_wstrb",   32'(WSTRB),   32'h4);
      chk("bw_awaddr",  AWADDR, 32'h2000_0002);
      chk("bw_wdata",   WDATA,  32'h0055_0000);
      tick; WREADY = 1'b0;
      samp;
      chk("bw_w_drop",   32'(WVALID),  32'd0);
      chk("bw_aw_hold",  32'(AWVALID), 32'd1);
      chk("bw_no_bready", 32'(BREADY), 32'd0);
      tick;
      tick; AWREADY = 1'b1; BVALID = 1'b1;
      samp;
      chk("bw_b_held_off", 32'(BREADY), 32'd0);
      chk("bw_b_early_wait", 32'(D_wait), 32'd1);
      chk("bw_aw_hold2", 32'(AWVALID), 32'd1);
      tick; AWREADY = 1'b0;
      samp;
      chk("bw_aw_drop", 32'(AWVALID), 32'd0);
      chk("bw_bready",  32'(BREADY),  32'd1);
      chk("bw_b_wait",  32'(D_wait),  32'd0);
      tick; BVALID = 1'b0;
      samp;
      chk("bw_done_bready", 32'(BREADY), 32'd0);
      chk("bw_done_wait",   32'(D_wait), 32'd1);
      tick;
      chk("bw_pulses", 32'(pulses - p0), 32'd1);

      // simultaneous read+write: write first, read dropped
      tick; D_wreq = 1'b1; D_rreq = 1'b1; D_type = T_HWORD;
      D_addr = 32'h3000_0002; D_in = 32'hBEEF_0000;
      p0 = pulses; a0 = ar_hs;
      tick; D_wreq = 1'b0; D_rreq = 1'b0; AWREADY = 1'b1; WREADY = 1'b1;
      samp;
      chk("col_awvalid", 32'(AWVALID), 32'd1);
      chk("col_arvalid", 32'(ARVALID), 32'd0);
      chk("col_wstrb",   32'(WSTRB),   32'hC);
      tick; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b1;
      samp;
      chk("col_aw_drop", 32'(AWVALID), 32'd0);
      chk("col_w_drop",  32'(WVALID),  32'd0);
      chk("col_b_wait",  32'(D_wait),  32'd0);
      tick; BVALID = 1'b0;
      samp; chk("col_done_noar", 32'(ARVALID), 32'd0);
      tick; samp; chk("col_idle_noar", 32'(ARVALID), 32'd0);
      chk("col_pulses", 32'(pulses - p0), 32'd1);
      tick; D_rreq = 1'b1; arlenone = 1'b1; D_addr = 32'h3000_0000;
      tick; D_rreq = 1'b0; arlenone = 1'b0;
      samp;
      chk("col_rereq_ar", 32'(ARVALID), 32'd1);
      chk("col_rereq_addr", ARADDR, 32'h3000_0000);
      tick; ARREADY = 1'b1;
      tick; ARREADY = 1'b0; RVALID = 1'b1; RDATA = 32'h1234_5678; RLAST = 1'b1;
      samp; chk("col_rereq_data", D_out, 32'h1234_5678);
      tick; RVALID = 1'b0; RLAST = 1'b0;
      tick;
      chk("col_ar_count", 32'(ar_hs - a0), 32'd1);

      // fill with RVALID gaps, D_rreq held high throughout
      tick; D_rreq = 1'b1; arlenone = 1'b0; D_addr = 32'h0002_0080;
      p0 = pulses; a0 = ar_hs;
      tick; ARREADY = 1'b1;
      samp; chk("stall_arvalid", 32'(ARVALID), 32'd1);
      tick; ARREADY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         repeat (gaps[i]) begin
            samp; chk("stall_gap_wait", 32'(D_wait), 32'd1);
            tick;
         end
         RVALID = 1'b1; RDATA = 32'h100 + 32'(i); RLAST = (i == 3);
         samp;
         chk("stall_beat_wait", 32'(D_wait), 32'd0);
         chk("stall_beat_data", D_out, 32'h100 + 32'(i));
         tick; RVALID = 1'b0; RLAST = 1'b0;
      end
      samp; chk("stall_done_rready", 32'(RREADY), 32'd0);
      tick; D_rreq = 1'b0;
      samp; chk("stall_no_second_ar", 32'(ARVALID), 32'd0);
      tick; samp; chk("stall_no_second_ar2", 32'(ARVALID), 32'd0);
      chk("stall_pulses", 32'(pulses - p0), 32'd4);
      chk("stall_ar_count", 32'(ar_hs - a0), 32'd1);

      // RLAST never asserted: beat counter ends the burst
      tick; D_rreq = 1'b1; arlenone = 1'b0; D_addr = 32'h0004_0000;
      p0 = pulses;
      tick; D_rreq = 1'b0; ARREADY = 1'b1;
      tick; ARREADY = 1'b0; RVALID = 1'b1; RLAST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         RDATA = 32'h200 + 32'(i);
         samp; chk("cnt_beat_wait", 32'(D_wait), 32'd0);
         tick;
      end
      RDATA = 32'h2FF;
      samp;
      chk("cnt_exit_rready", 32'(RREADY), 32'd0);
      chk("cnt_exit_wait",   32'(D_wait), 32'd1);
      tick; RVALID = 1'b0;
      chk("cnt_pulses", 32'(pulses - p0), 32'd4);

      // reset asserted during beat 2 of a fill
      tick; D_rreq = 1'b1; D_addr = 32'h0005_0000;
      tick; D_rreq = 1'b0; ARREADY = 1'b1;
      tick; ARREADY = 1'b0; RVALID = 1'b1; RLAST = 1'b0;
      for (int i = 0; i < 2; i++) begin
         RDATA = 32'h300 + 32'(i);
         samp; tick;
      end
      RDATA = 32'h302;
      samp; chk("rst_mid_beat2", 32'(D_wait), 32'd0);
      #2 rstn = 1'b0;
      #1;
      chk("rst_mid_rready", 32'(RREADY), 32'd0);
      chk("rst_mid_wait",   32'(D_wait), 32'd1);
      chk("rst_mid_dout",   D_out, 32'd0);
      tick; RVALID = 1'b0;
      tick; rstn = 1'b1;

      // a fresh fill after reset completes normally
      tick; D_rreq = 1'b1; D_addr = 32'h0006_0000;
      p0 = pulses; a0 = ar_hs;
      tick; D_rreq = 1'b0; ARREADY = 1'b1;
      samp;
      chk("post_arvalid", 32'(ARVALID), 32'd1);
      chk("post_araddr",  ARADDR, 32'h0006_0000);
      chk("post_arlen",   32'(ARLEN), 32'd3);
      tick; ARREADY = 1'b0; RVALID = 1'b1;
      for (int i = 0; i < 4; i++) begin
         RDATA = 32'h400 + 32'(i); RLAST = (i == 3);
         samp; chk("post_beat_data", D_out, 32'h400 + 32'(i));
         tick;
      end
      RVALID = 1'b0; RLAST = 1'b0;
      samp; chk("post_done_rready", 32'(RREADY), 32'd0);
      tick;
      chk("post_pulses", 32'(pulses - p0), 32'd4);
      chk("post_ar_count", 32'(ar_hs - a0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
